lsq_mem_responder: RTL
======================

# lsq_mem_responder

Data-memory responder at the far end of the load-store queue's issue port. It accepts word load and store requests tagged with the instruction PC, buffers them in order in a small FIFO, and services each one against an internal word-addressed memory after a fixed access latency. It returns one response per request: load data or store acknowledge, tagged with the same PC, so the LSQ can complete loads and mark stores done.

## Interface
Parameters:
- MEM_WORDS, 1024: memory depth in 32-bit words; power of 2.
- QDEPTH, 4: request FIFO depth; power of 2, at least 2.
- LAT, 2: access latency in cycles spent in BUSY; at least 1.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  FIFO can accept; equals !full.
- req_pc  in  32  instruction PC tag.
- req_addr  in  32  byte address.
- req_store  in  1  0 = load, 1 = store.
- req_wdata  in  32  store data; ignored for loads.
- resp_valid  out  1  response present; held until accepted.
- resp_ready  in  1  consumer accepts the response.
- resp_pc  out  32  PC tag of the serviced request.
- resp_store  out  1  op type of the serviced request.
- resp_data  out  32  load data; 0 for stores and errors.
- resp_err  out  1  misaligned access.

## Operation
- Request FIFO: a request is pushed when req_valid && req_ready. Storage is in order, with wrap-around read/write pointers and a count of width log2(QDEPTH)+1.
- req_ready = (count != QDEPTH). A pop in the same cycle does not raise ready; this is a deliberate conservative choice.
- Service FSM, states IDLE, BUSY and RESP:
  - IDLE: if the FIFO is non-empty, pop the head into the service registers, set cnt = LAT-1, and go to BUSY.
  - BUSY: if cnt != 0, decrement. If cnt == 0, perform the access and go to RESP.
  - RESP: resp_valid = 1. On resp_ready, if the FIFO is non-empty, pop the next request and go straight to BUSY; otherwise go to IDLE.
- Access rules:
  - Word index = addr[log2(MEM_WORDS)+1:2]. Upper address bits are ignored, so out-of-range addresses alias.
  - addr[1:0] != 0 sets resp_err = 1, suppresses the store write, and sets resp_data = 0.
  - Aligned store: writes mem[index] = wdata; resp_data = 0.
  - Aligned load: resp_data = mem[index], reading the memory state that includes every earlier serviced store.
- Ordering: strictly FIFO. Responses come back in acceptance order, so a load after a store to the same address always returns the stored data.
- Response outputs are registered and stable while resp_valid = 1 and resp_ready = 0.

## Timing
- Reset (synchronous, rst = 1 at an edge):
  - FIFO emptied, state = IDLE, cnt = 0.
  - resp_valid = 0, resp_pc = 0, resp_store = 0, resp_data = 0, resp_err = 0.
  - All memory words cleared to 0.
  - req_ready = 1 in the cycle after reset.
- Reset mid-operation discards everything: queued requests, any BUSY access (a pending store is not written), and a held response.
- Latency with the unit idle and the FIFO empty:
  - Accept at edge E0, pop at E1, access at edge E0+LAT+1.
  - resp_valid is high in the cycle after E0+LAT+1 (LAT+1 edges after accept).
- Throughput: one response per LAT+1 cycles when resp_ready is held high, because the RESP handshake and the next pop share an edge.
- Full FIFO: req_ready = 0; req_valid is ignored and nothing is dropped or overwritten. A request held across the full period is accepted on the first cycle req_ready = 1.
- Simultaneous push and pop at count = QDEPTH-1: both happen, and count is unchanged.
- Push into an empty FIFO while in IDLE: the pop occurs on the next edge, never the same edge.

## Test plan
- Reset: assert rst for 2 cycles with req_valid = 1 -> all outputs 0, req_ready = 1 after release, no request accepted during reset.
- Store then load:
  - store pc=0x10, addr=0x40, wdata=0xDEADBEEF, then load pc=0x14, addr=0x40, with resp_ready = 1.
  - Required: resp {0x10, store=1, data=0} 3 cycles after accept, then {0x14, store=0, data=0xDEADBEEF}.
- Misaligned store: store addr=0x41, wdata=0x1234 -> resp_err = 1. A following aligned load of addr=0x40 returns 0.
- Backpressure:
  - hold resp_ready = 0 and issue 6 loads back-to-back.
  - Required: exactly 5 accepted (4 in the FIFO, 1 in service), req_ready = 0 afterwards, response stable.
  - Then raise resp_ready -> 5 responses in PC order.
- Aliasing: store to addr = 0x40 + MEM_WORDS*4, then load 0x40 -> returns the stored data.
- Reset mid-BUSY: accept a store to 0x80, assert rst one cycle later -> no response, and a later load of 0x80 returns 0.

Source files
------------

// File: rtl/lsq_mem_responder.sv
// Data-memory responder for the LSQ issue port: in-order request FIFO feeding a
// fixed-latency word memory, one tagged response per request.
//
// state  | meaning
// IDLE   | nothing in service, waiting for the FIFO to fill
// BUSY   | request in service, counting down the access latency
// RESP   | response registered and held until the consumer accepts it
module lsq_mem_responder #(
    parameter int MEM_WORDS = 1024,
    parameter int QDEPTH    = 4,
    parameter int LAT       = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_req_pc,
    input  logic [31:0] i_req_addr,
    input  logic        i_req_store,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    input  logic        i_resp_ready,
    output logic [31:0] o_resp_pc,
    output logic        o_resp_store,
    output logic [31:0] o_resp_data,
    output logic        o_resp_err
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int QW = $clog2(QDEPTH);
    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;
    state_t r_state, w_state_nxt;

    logic [31:0]   r_q_pc    [QDEPTH];
    logic [AW+1:0] r_q_addr  [QDEPTH];
    logic          r_q_store [QDEPTH];
    logic [31:0]   r_q_wdata [QDEPTH];
    logic [QW-1:0] r_wptr, r_rptr;
    logic [QW:0]   r_count;

    logic [31:0]   r_svc_pc, r_svc_wdata;
    logic [AW+1:0] r_svc_addr;
    logic          r_svc_store;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_mem [MEM_WORDS];

    logic          r_resp_valid, r_resp_store, r_resp_err;
    logic [31:0]   r_resp_pc, r_resp_data;

    logic          w_push, w_pop, w_access, w_empty, w_misal;
    logic [AW-1:0] w_idx;
    logic          w_unused_addr;

    // Upper address bits alias onto the memory and are intentionally dropped.
    assign w_unused_addr = ^i_req_addr[31:AW+2];

    assign o_req_ready = (r_count != (QW+1)'(QDEPTH));
    assign w_push      = i_req_valid && o_req_ready;
    assign w_empty     = (r_count == '0);
    assign w_idx       = r_svc_addr[AW+1:2];
    assign w_misal     = (r_svc_addr[1:0] != 2'b00);

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_q_pc[r_wptr]    <= i_req_pc;
            r_q_addr[r_wptr]  <= i_req_addr[AW+1:0];
            r_q_store[r_wptr] <= i_req_store;
            r_q_wdata[r_wptr] <= i_req_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + QW'(1);
            if (w_pop)  r_rptr <= r_rptr + QW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (QW+1)'(1);
                2'b01:   r_count <= r_count - (QW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_access    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_cnt == '0) begin
                    w_access    = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                // Handshake and next pop share an edge to sustain LAT+1 throughput.
                if (i_resp_ready) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = S_BUSY;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_svc_pc     <= '0;
            r_svc_addr   <= '0;
            r_svc_store  <= 1'b0;
            r_svc_wdata  <= '0;
            r_resp_valid <= 1'b0;
            r_resp_pc    <= '0;
            r_resp_store <= 1'b0;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b0;
            for (int i = 0; i < MEM_WORDS; i++) r_mem[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pop) begin
                r_svc_pc    <= r_q_pc[r_rptr];
                r_svc_addr  <= r_q_addr[r_rptr];
                r_svc_store <= r_q_store[r_rptr];
                r_svc_wdata <= r_q_wdata[r_rptr];
                r_cnt       <= CW'(LAT - 1);
            end else if (r_state == S_BUSY && r_cnt != '0) begin
                r_cnt <= r_cnt - CW'(1);
            end
            if (w_access) begin
                r_resp_valid <= 1'b1;
                r_resp_pc    <= r_svc_pc;
                r_resp_store <= r_svc_store;
                r_resp_err   <= w_misal;
                r_resp_data  <= (w_misal || r_svc_store) ? 32'h0 : r_mem[w_idx];
                if (!w_misal && r_svc_store) r_mem[w_idx] <= r_svc_wdata;
            end else if (r_state == S_RESP && i_resp_ready) begin
                r_resp_valid <= 1'b0;
            end
        end
    end

    assign o_resp_valid = r_resp_valid;
    assign o_resp_pc    = r_resp_pc;
    assign o_resp_store = r_resp_store;
    assign o_resp_data  = r_resp_data;
    assign o_resp_err   = r_resp_err;
endmodule
